// File: rtl/pid_integ_gen.sv
// Integral term of the PID loop: decimated, holdable, preloadable accumulator
// with a freeze/clamp overflow policy and a registered, valid-qualified output.
module pid_integ_gen #(
   parameter int unsigned ERR_W     = 10,
   parameter int unsigned ACC_W     = 15,
   parameter int unsigned OUT_SHIFT = 6,
   parameter int unsigned DECIM     = 1,
   parameter int unsigned SAT_MODE  = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         moving,
   input  logic                         err_vld,
   input  logic [ERR_W-1:0]             err_sat,
   input  logic                         hold,
   input  logic                         preload_en,
   input  logic [ACC_W-1:0]             preload_val,
   output logic [ACC_W-OUT_SHIFT-1:0]   I_term,
   output logic                         I_vld,
   output logic                         sat_flag
);

   localparam int unsigned OUT_W = ACC_W - OUT_SHIFT;
   localparam int unsigned CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);
   localparam logic [ACC_W-1:0] POS_RAIL = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] NEG_RAIL = {1'b1, {(ACC_W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

   state_t           state;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic             upd;
   logic [ACC_W:0]   sum;
   logic             ovf;

   // One-bit-wider sum; overflow when the two top bits disagree
   always_comb begin
      sum = {acc[ACC_W-1], acc} + {{(ACC_W+1-ERR_W){err_sat[ERR_W-1]}}, err_sat};
      ovf = sum[ACC_W] ^ sum[ACC_W-1];
   end

   // Control FSM, accumulator update and one-cycle-delayed output register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         acc      <= '0;
         cnt      <= '0;
         upd      <= 1'b0;
         I_term   <= '0;
         I_vld    <= 1'b0;
         sat_flag <= 1'b0;
      end else begin
         I_term <= OUT_W'(acc[ACC_W-1:OUT_SHIFT]);
         I_vld  <= upd;
         upd    <= 1'b0;
         if (!moving) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            sat_flag <= 1'b0;
            upd      <= |acc;
         end else begin
            case (state)
               IDLE: state <= RUN;
               RUN, HOLD: begin
                  if (preload_en) begin
                     acc <= preload_val;
                     cnt <= '0;
                     upd <= 1'b1;
                  end else if (hold) begin
                     state <= HOLD;
                  end else if (state == HOLD) begin
                     state <= RUN;
                  end else if (err_vld) begin
                     if (cnt != CNT_LAST) begin
                        cnt <= cnt + CNT_W'(1);
                     end else begin
                        cnt <= '0;
                        upd <= 1'b1;
                        if (!ovf) begin
                           acc <= sum[ACC_W-1:0];
                        end else begin
                           sat_flag <= 1'b1;
                           if (SAT_MODE != 0)
                              acc <= sum[ACC_W] ? NEG_RAIL : POS_RAIL;
                        end
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pid_integ_gen.sv
// Directed bench: three instances (freeze, clamp, DECIM=4) share one stimulus.
module tb_pid_integ_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        moving;
   logic        err_vld;
   logic [9:0]  err_sat;
   logic        hold;
   logic        preload_en;
   logic [14:0] preload_val;
   logic [8:0]  it0, it1, it4;
   logic        iv0, iv1, iv4;
   logic        sf0, sf1, sf4;

   int ncmp = 0;
   int nfail = 0;

   always #5 clk = ~clk;

   pid_integ_gen #(.SAT_MODE(0)) dut0 (
      .clk(clk), .rst(rst), .moving(moving), .err_vld(err_vld), .err_sat(err_sat),
      .hold(hold), .preload_en(preload_en), .preload_val(preload_val),
      .I_term(it0), .I_vld(iv0), .sat_flag(sf0));

   pid_integ_gen #(.SAT_MODE(1)) dut1 (
      .clk(clk), .rst(rst), .moving(moving), .err_vld(err_vld), .err_sat(err_sat),
      .hold(hold), .preload_en(preload_en), .preload_val(preload_val),
      .I_term(it1), .I_vld(iv1), .sat_flag(sf1));

   pid_integ_gen #(.DECIM(4)) dut4 (
      .clk(clk), .rst(rst), .moving(moving), .err_vld(err_vld), .err_sat(err_sat),
      .hold(hold), .preload_en(preload_en), .preload_val(preload_val),
      .I_term(it4), .I_vld(iv4), .sat_flag(sf4));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Drop moving for two edges (clear + output settle), then re-enter RUN
   task automatic restart();
      moving = 1'b0; err_vld = 1'b0; hold = 1'b0; preload_en = 1'b0;
      cyc();
      cyc();
      moving = 1'b1;
      cyc();
   endtask

   task automatic preload(input logic [14:0] v);
      preload_en = 1'b1; preload_val = v;
      cyc();
      preload_en = 1'b0;
   endtask

   initial begin
      rst = 1'b1; moving = 1'b0; err_vld = 1'b0; err_sat = '0;
      hold = 1'b0; preload_en = 1'b0; preload_val = '0;
      #12;
      chk("rst_I_term", 32'(it0), 32'h0);
      chk("rst_I_vld", 32'(iv0), 32'h0);
      chk("rst_sat", 32'(sf0), 32'h0);
      @(negedge clk); rst = 1'b0;

      // Test 1: three +100 samples
      moving = 1'b1;
      cyc();
      err_vld = 1'b1; err_sat = 10'd100;
      cyc();
      chk("t1_acc_100", 32'(dut0.acc), 32'd100);
      cyc();
      chk("t1_vld_1", 32'(iv0), 32'h1);
      cyc();
      chk("t1_vld_2", 32'(iv0), 32'h1);
      err_vld = 1'b0;
      cyc();
      chk("t1_I_term", 32'(it0), 32'd4);
      chk("t1_vld_3", 32'(iv0), 32'h1);
      chk("t1_sat", 32'(sf0), 32'h0);
      cyc();
      chk("t1_vld_end", 32'(iv0), 32'h0);

      // Test 2a: freeze on positive overflow
      restart();
      preload(15'h3FFF);
      cyc();
      chk("t2_pre_vld", 32'(iv0), 32'h1);
      chk("t2_pre_I_term", 32'(it0), 32'hFF);
      err_vld = 1'b1; err_sat = 10'd1;
      cyc();
      err_vld = 1'b0;
      chk("t2_freeze_acc", 32'(dut0.acc), 32'h3FFF);
      chk("t2_freeze_sat", 32'(sf0), 32'h1);
      cyc();
      chk("t2_freeze_vld", 32'(iv0), 32'h1);
      chk("t2_freeze_I_term", 32'(it0), 32'hFF);

      // Test 2b: clamp to positive rail
      restart();
      chk("t2_clr_sat1", 32'(sf1), 32'h0);
      preload(15'd16300);
      err_vld = 1'b1; err_sat = 10'd200;
      cyc();
      err_vld = 1'b0;
      chk("t2_clamp_acc", 32'(dut1.acc), 32'h3FFF);
      chk("t2_clamp_sat", 32'(sf1), 32'h1);
      chk("t2_m0_acc", 32'(dut0.acc), 32'd16300);
      chk("t2_m0_sat", 32'(sf0), 32'h1);

      // Test 3: clamp to negative rail
      restart();
      preload(15'h4054);               // -16300
      err_vld = 1'b1; err_sat = 10'h200; // -512
      cyc();
      err_vld = 1'b0;
      chk("t3_clamp_acc", 32'(dut1.acc), 32'h4000);
      chk("t3_clamp_sat", 32'(sf1), 32'h1);
      chk("t3_m0_acc", 32'(dut0.acc), 32'h4054);
      cyc();
      chk("t3_I_term", 32'(it1), 32'h100);

      // Test 4: DECIM=4, eight +10 samples
      restart();
      err_vld = 1'b1; err_sat = 10'd10;
      for (int k = 1; k <= 8; k++) begin
         cyc();
         chk($sformatf("t4_vld_%0d", k), 32'(iv4), (k == 5) ? 32'h1 : 32'h0);
      end
      err_vld = 1'b0;
      cyc();
      chk("t4_vld_last", 32'(iv4), 32'h1);
      chk("t4_acc", 32'(dut4.acc), 32'd20);

      // Test 5: hold, release, then drop moving
      restart();
      chk("t5_clr_sat0", 32'(sf0), 32'h0);
      preload(15'd500);
      hold = 1'b1; err_vld = 1'b1; err_sat = 10'd50;
      for (int k = 0; k < 5; k++) cyc();
      chk("t5_hold_acc", 32'(dut0.acc), 32'd500);
      hold = 1'b0; err_vld = 1'b0;
      cyc();
      err_vld = 1'b1;
      cyc();
      err_vld = 1'b0;
      chk("t5_acc_550", 32'(dut0.acc), 32'd550);
      cyc();
      chk("t5_I_term", 32'(it0), 32'd8);
      moving = 1'b0;
      cyc();
      chk("t5_clr_acc", 32'(dut0.acc), 32'h0);
      chk("t5_clr_state", 32'(dut0.state), 32'h0);
      cyc();
      chk("t5_clr_I_term", 32'(it0), 32'h0);
      chk("t5_clr_vld", 32'(iv0), 32'h1);

      // Test 6: async reset mid-integration
      moving = 1'b1;
      cyc();
      preload(15'd1234);
      err_vld = 1'b1; err_sat = 10'd6;
      cyc();
      err_vld = 1'b0;
      cyc();
      chk("t6_pre_I_term", 32'(it0), 32'd19);
      chk("t6_pre_vld", 32'(iv0), 32'h1);
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_I_term", 32'(it0), 32'h0);
      chk("t6_rst_vld", 32'(iv0), 32'h0);
      chk("t6_rst_sat", 32'(sf0), 32'h0);
      chk("t6_rst_acc", 32'(dut0.acc), 32'h0);
      @(negedge clk); rst = 1'b0;
      cyc();
      err_vld = 1'b1; err_sat = 10'd7;
      cyc();
      err_vld = 1'b0;
      chk("t6_acc_7", 32'(dut0.acc), 32'd7);
      cyc();
      chk("t6_vld", 32'(iv0), 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule

// File: doc/pid_integ_gen.md
Name: pid_integ_gen

Overview:
Parametrised integral-term block for the PID loop; successor of the fixed 10-bit error / 15-bit accumulator I-term.
- Generalised widths and output scaling.
- Selectable overflow policy: freeze or clamp.
- Sample decimation, hold, preload and a sticky saturation flag.
- Registered, valid-qualified I-term output.

Sits between the error saturator and the PID summer.

Parameters:
ERR_W, 10, signed error input width
ACC_W, 15, signed accumulator width (must be > ERR_W)
OUT_SHIFT, 6, accumulator LSBs dropped to form I_term; OUT_W = ACC_W - OUT_SHIFT
DECIM, 1, integrate on every DECIM-th valid error sample (>=1)
SAT_MODE, 0, 0 = freeze accumulator on overflow, 1 = clamp to signed rail

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
moving  in  1  motion enable; low clears integrator and returns to IDLE
err_vld  in  1  err_sat valid this cycle
err_sat  in  ERR_W  signed saturated error
hold  in  1  freeze integration (samples ignored, count kept)
preload_en  in  1  load preload_val into accumulator this cycle
preload_val  in  ACC_W  signed preload value
I_term  out  OUT_W  registered accumulator[ACC_W-1:OUT_SHIFT]
I_vld  out  1  one-cycle pulse: I_term reflects a new accumulator value
sat_flag  out  1  sticky: an overflow occurred since last clear

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high. On rst, all of the following are zero:
  - state = IDLE
  - accumulator
  - decimation count
  - I_term, I_vld, sat_flag
- States:
  - IDLE: accumulator held at 0, count 0. moving=1 -> RUN.
  - RUN: integrates.
    - hold=1 -> HOLD.
    - moving=0 -> IDLE.
  - HOLD: no accumulation; err_vld ignored; count preserved.
    - hold=0 -> RUN.
    - moving=0 -> IDLE.
- Per-edge priority: moving=0 (clear acc, count, sat_flag; go IDLE) > preload_en (RUN/HOLD only) > hold > accumulate.
  - Preload in IDLE is ignored.
- Preload:
  - accumulator <= preload_val, count <= 0.
  - Does not set sat_flag.
  - State unchanged.
- Accumulate (RUN, hold=0, err_vld=1):
  - If count < DECIM-1: count++, accumulator unchanged.
  - Else: count <= 0, sum = acc + sign_ext(err_sat), computed in ACC_W+1 bits.
  - Overflow = sum outside [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - No overflow: acc <= sum.
  - Overflow, SAT_MODE=0: acc unchanged.
  - Overflow, SAT_MODE=1: acc <= positive rail 2^(ACC_W-1)-1 or negative rail -2^(ACC_W-1), matching the direction of overflow.
  - Any overflow sets sat_flag the same edge.
- DECIM=1: every valid sample integrates.
- Latency:
  - Accumulator updates on the edge sampling err_vld/preload_en.
  - I_term and I_vld update on the following edge (1-cycle registered output).
  - I_vld pulses for one cycle after each integrating or preload update, including frozen or clamped overflow updates.
  - I_vld does not pulse for decimation-skipped samples.
  - I_vld pulses after a moving=0 clear only if the accumulator was non-zero.
- I_term is an arithmetic truncation of the accumulator (floor toward negative infinity).
- Simultaneous events:
  - preload_en with err_vld: preload wins, sample dropped.
  - hold with preload_en: preload applies.
  - moving falling in any state: accumulator 0 at that edge, I_term 0 one edge later.
- Reset mid-operation: outputs zero immediately (asynchronous); restart from IDLE on deassertion.

Test Plan:
1. Defaults; rst pulse, moving=1, three err_vld cycles with err_sat=+100 -> accumulator 300; I_term = 4 one cycle after the last sample; I_vld pulses 3 times; sat_flag=0.
2. SAT_MODE=0: preload 16383 (I_vld pulses, I_term 255), then err_sat=+1 -> accumulator stays 16383, I_term=255, sat_flag=1. SAT_MODE=1: preload 16300, err_sat=+200 -> accumulator 16383, sat_flag=1.
3. SAT_MODE=1: preload -16300, err_sat=-512 -> accumulator -16384, I_term = -256 (9'h100); sat_flag=1.
4. DECIM=4: eight err_vld samples of +10 -> accumulator 20; I_vld pulses only on the 4th and 8th samples (+1 cycle).
5. RUN at accumulator 500: hold=1 with 5 samples of +50 -> still 500. Release hold, one sample -> 550. Drop moving -> accumulator 0, I_term 0 next edge, sat_flag cleared, state IDLE.
6. Async rst asserted mid-cycle during integration (accumulator 1234) -> I_term, I_vld, sat_flag zero immediately without a clock edge. After release with moving=1, first sample +7 -> accumulator 7.
